// File: rtl/exa_crosb_vc_credit_switch.sv
// exa_crosb_vc_credit_switch
// Packet crossbar between the input VC FIFOs and the output class FIFOs.
// Each output runs an IDLE/LOCKED FSM: in IDLE it picks one eligible input
// (round-robin, optionally restricted to the most urgent priority class),
// then stays locked to that input until the tlast beat. Credits per
// (output, class) mirror free slots in the downstream class FIFOs.
//
// Handshake: an input flit transfers on a rising edge where
// s_tvalid[i] & s_tready[i] are both high. s_tready[i] is only ever high
// for an input locked to an output whose latched class has credits left,
// and it never depends on s_tvalid. m_tvalid[o] marks the same transfer as
// a write into class FIFO m_tvc[o] of output o (no backpressure on m_*).
module exa_crosb_vc_credit_switch #(
    parameter int DATA_WIDTH   = 128,
    parameter int INPUT_NUM    = 4,
    parameter int OUTPUT_NUM   = 4,
    parameter int VC_NUM       = 2,
    parameter int PRIO_NUM     = 2,
    parameter int CREDIT_DEPTH = 8,
    parameter int STRICT_PRIO  = 1,
    localparam int CLS = VC_NUM * PRIO_NUM,
    localparam int ISW = $clog2(INPUT_NUM),
    localparam int OSW = $clog2(OUTPUT_NUM),
    localparam int VCW = $clog2(CLS),
    localparam int CW  = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [INPUT_NUM*DATA_WIDTH-1:0]  s_tdata,
    input  logic [INPUT_NUM-1:0]             s_tvalid,
    input  logic [INPUT_NUM-1:0]             s_tlast,
    input  logic [INPUT_NUM*OSW-1:0]         s_tdest,
    input  logic [INPUT_NUM*VCW-1:0]         s_tvc,
    output logic [INPUT_NUM-1:0]             s_tready,
    output logic [OUTPUT_NUM*DATA_WIDTH-1:0] m_tdata,
    output logic [OUTPUT_NUM-1:0]            m_tvalid,
    output logic [OUTPUT_NUM-1:0]            m_tlast,
    output logic [OUTPUT_NUM*VCW-1:0]        m_tvc,
    input  logic [OUTPUT_NUM*CLS-1:0]        i_credit_return,
    output logic [OUTPUT_NUM*CLS*CW-1:0]     o_credits,
    output logic [OUTPUT_NUM*ISW-1:0]        o_sel_input,
    output logic [OUTPUT_NUM-1:0]            o_out_busy,
    output logic                             o_credit_overflow
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         r_state    [OUTPUT_NUM];
    state_t         w_state_nxt[OUTPUT_NUM];
    logic [ISW-1:0] r_sel      [OUTPUT_NUM];
    logic [ISW-1:0] w_sel_nxt  [OUTPUT_NUM];
    logic [VCW-1:0] r_vc       [OUTPUT_NUM];
    logic [VCW-1:0] w_vc_nxt   [OUTPUT_NUM];
    logic [ISW-1:0] r_rr       [OUTPUT_NUM];
    logic [ISW-1:0] w_rr_nxt   [OUTPUT_NUM];
    logic [CW-1:0]  r_credits  [OUTPUT_NUM][CLS];
    logic           r_overflow;

    logic [OUTPUT_NUM-1:0]     w_busy;
    logic [OUTPUT_NUM-1:0]     w_out_ok;
    logic [OUTPUT_NUM-1:0]     w_fire;
    logic [INPUT_NUM-1:0]      w_in_locked;
    logic [INPUT_NUM-1:0]      w_elig   [OUTPUT_NUM];
    logic [OUTPUT_NUM-1:0]     w_win_found;
    logic [ISW-1:0]            w_win    [OUTPUT_NUM];
    logic [OUTPUT_NUM*CLS-1:0] w_take;

    function automatic int prio_of(input logic [VCW-1:0] vc);
        return int'(vc) / VC_NUM;
    endfunction

    // Lock bookkeeping: which inputs are owned by an output and may send.
    always_comb begin
        w_in_locked = '0;
        s_tready    = '0;
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            w_busy[o]   = (r_state[o] == ST_LOCKED);
            w_out_ok[o] = (r_credits[o][r_vc[o]] != '0);
            for (int i = 0; i < INPUT_NUM; i++) begin
                if (w_busy[o] && (r_sel[o] == ISW'(i))) begin
                    w_in_locked[i] = 1'b1;
                    s_tready[i]    = w_out_ok[o];
                end
            end
        end
    end

    // Output datapath: pass the locked input through, zero when idle.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = '0;
        m_tlast  = '0;
        m_tvc    = '0;
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            if (w_busy[o]) begin
                m_tdata[o*DATA_WIDTH +: DATA_WIDTH] = s_tdata[int'(r_sel[o])*DATA_WIDTH +: DATA_WIDTH];
                m_tvalid[o]                         = s_tvalid[r_sel[o]] & w_out_ok[o];
                m_tlast[o]                          = s_tlast[r_sel[o]];
                m_tvc[o*VCW +: VCW]                 = r_vc[o];
            end
        end
    end

    assign w_fire = m_tvalid;

    // Arbitration: eligible set, optional priority filter, round-robin pick.
    always_comb begin
        int max_p;
        int idx;
        max_p = 0;
        idx   = 0;
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            w_elig[o]      = '0;
            w_win_found[o] = 1'b0;
            w_win[o]       = '0;
            max_p          = 0;
            for (int i = 0; i < INPUT_NUM; i++) begin
                w_elig[o][i] = s_tvalid[i]
                            && (s_tdest[i*OSW +: OSW] == OSW'(o))
                            && (r_credits[o][s_tvc[i*VCW +: VCW]] != '0)
                            && !w_in_locked[i];
                if (w_elig[o][i] && (prio_of(s_tvc[i*VCW +: VCW]) > max_p))
                    max_p = prio_of(s_tvc[i*VCW +: VCW]);
            end
            if (STRICT_PRIO != 0) begin
                for (int i = 0; i < INPUT_NUM; i++) begin
                    if (prio_of(s_tvc[i*VCW +: VCW]) < max_p)
                        w_elig[o][i] = 1'b0;
                end
            end
            for (int k = 0; k < INPUT_NUM; k++) begin
                idx = (int'(r_rr[o]) + k) % INPUT_NUM;
                if (!w_win_found[o] && w_elig[o][idx]) begin
                    w_win_found[o] = 1'b1;
                    w_win[o]       = ISW'(idx);
                end
            end
        end
    end

    // Per-output FSM next state: grant in IDLE, release after the tlast beat.
    always_comb begin
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            w_state_nxt[o] = r_state[o];
            w_sel_nxt[o]   = r_sel[o];
            w_vc_nxt[o]    = r_vc[o];
            w_rr_nxt[o]    = r_rr[o];
            case (r_state[o])
                ST_IDLE: begin
                    if (w_win_found[o]) begin
                        w_state_nxt[o] = ST_LOCKED;
                        w_sel_nxt[o]   = w_win[o];
                        w_vc_nxt[o]    = s_tvc[int'(w_win[o])*VCW +: VCW];
                    end
                end
                ST_LOCKED: begin
                    if (w_fire[o] && s_tlast[r_sel[o]]) begin
                        w_state_nxt[o] = ST_IDLE;
                        w_rr_nxt[o]    = (r_sel[o] == ISW'(INPUT_NUM - 1)) ? '0 : r_sel[o] + ISW'(1);
                    end
                end
                default: w_state_nxt[o] = ST_IDLE;
            endcase
        end
    end

    // FSM state registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            if (reset) begin
                r_state[o] <= ST_IDLE;
                r_sel[o]   <= '0;
                r_vc[o]    <= '0;
                r_rr[o]    <= '0;
            end else begin
                r_state[o] <= w_state_nxt[o];
                r_sel[o]   <= w_sel_nxt[o];
                r_vc[o]    <= w_vc_nxt[o];
                r_rr[o]    <= w_rr_nxt[o];
            end
        end
    end

    // One-hot-per-output map of which (output, class) consumes a slot now.
    always_comb begin
        w_take = '0;
        for (int o = 0; o < OUTPUT_NUM; o++)
            for (int c = 0; c < CLS; c++)
                w_take[o*CLS + c] = w_fire[o] && (r_vc[o] == VCW'(c));
    end

    // Credit counters: take and return in one cycle cancel; returns saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            for (int o = 0; o < OUTPUT_NUM; o++)
                for (int c = 0; c < CLS; c++)
                    r_credits[o][c] <= CW'(CREDIT_DEPTH);
        end else begin
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                for (int c = 0; c < CLS; c++) begin
                    if (i_credit_return[o*CLS + c] && !w_take[o*CLS + c]) begin
                        if (r_credits[o][c] == CW'(CREDIT_DEPTH))
                            r_overflow <= 1'b1;
                        else
                            r_credits[o][c] <= r_credits[o][c] + CW'(1);
                    end else if (w_take[o*CLS + c] && !i_credit_return[o*CLS + c]) begin
                        r_credits[o][c] <= r_credits[o][c] - CW'(1);
                    end
                end
            end
        end
    end

    // Status outputs flattened from the registered state.
    always_comb begin
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            o_sel_input[o*ISW +: ISW] = r_sel[o];
            for (int c = 0; c < CLS; c++)
                o_credits[(o*CLS + c)*CW +: CW] = r_credits[o][c];
        end
    end

    assign o_out_busy        = w_busy;
    assign o_credit_overflow = r_overflow;

endmodule

// File: tb/tb_exa_crosb_vc_credit_switch.sv
// tb_exa_crosb_vc_credit_switch
// Directed bench: per-input driver tasks, per-output expected-flit queues
// popped by a monitor, plus direct checks on lock state and credits.
module tb_exa_crosb_vc_credit_switch;

    localparam int DW  = 32;
    localparam int NI  = 4;
    localparam int NO  = 4;
    localparam int CLS = 4;
    localparam int CW  = 4;
    localparam int EW  = 2 + 1 + DW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NI*DW-1:0]  s_tdata;
    logic [NI-1:0]     s_tvalid;
    logic [NI-1:0]     s_tlast;
    logic [NI*2-1:0]   s_tdest;
    logic [NI*2-1:0]   s_tvc;
    logic [NI-1:0]     s_tready;
    logic [NO*DW-1:0]  m_tdata;
    logic [NO-1:0]     m_tvalid;
    logic [NO-1:0]     m_tlast;
    logic [NO*2-1:0]   m_tvc;
    logic [NO*CLS-1:0] credit_ret;
    logic [NO*CLS*CW-1:0] o_credits;
    logic [NO*2-1:0]   o_sel_input;
    logic [NO-1:0]     o_out_busy;
    logic              o_credit_overflow;

    logic [DW-1:0] drv_data [NI];
    logic          drv_valid[NI];
    logic          drv_last [NI];
    logic [1:0]    drv_dest [NI];
    logic [1:0]    drv_vc   [NI];

    logic [EW-1:0] exp_q[NO][$];
    int            cyc_log1[$];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    exa_crosb_vc_credit_switch #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s_tdata          (s_tdata),
        .s_tvalid         (s_tvalid),
        .s_tlast          (s_tlast),
        .s_tdest          (s_tdest),
        .s_tvc            (s_tvc),
        .s_tready         (s_tready),
        .m_tdata          (m_tdata),
        .m_tvalid         (m_tvalid),
        .m_tlast          (m_tlast),
        .m_tvc            (m_tvc),
        .i_credit_return  (credit_ret),
        .o_credits        (o_credits),
        .o_sel_input      (o_sel_input),
        .o_out_busy       (o_out_busy),
        .o_credit_overflow(o_credit_overflow)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pack per-input driver state onto the DUT buses.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            s_tdata[i*DW +: DW] = drv_data[i];
            s_tvalid[i]         = drv_valid[i];
            s_tlast[i]          = drv_last[i];
            s_tdest[i*2 +: 2]   = drv_dest[i];
            s_tvc[i*2 +: 2]     = drv_vc[i];
        end
    end

    // Time bound on the whole run.
    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(input int i, input int p, input int f);
        return {8'(i), 8'(p), 16'(f)};
    endfunction

    function automatic logic [CW-1:0] cred(input int o, input int c);
        return o_credits[(o*CLS + c)*CW +: CW];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pkt(input int i, input int dest, input int vc, input int len, input int pid);
        for (int f = 0; f < len; f++)
            exp_q[dest].push_back({2'(vc), (f == len - 1), mk(i, pid, f)});
    endtask

    // Drive one packet on input i; must be called just after a rising edge.
    task automatic send_pkt(input int i, input int dest, input int vc, input int len, input int pid);
        bit acc;
        int n;
        for (int f = 0; f < len; f++) begin
            drv_valid[i] = 1'b1;
            drv_data[i]  = mk(i, pid, f);
            drv_last[i]  = (f == len - 1);
            drv_dest[i]  = 2'(dest);
            drv_vc[i]    = 2'(vc);
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 200) begin
                @(negedge clk);
                acc = s_tready[i];
                @(posedge clk);
                #1;
                n++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send_timeout in%0d: got no s_tready required acceptance of flit %0d", i, f);
                break;
            end
        end
        drv_valid[i] = 1'b0;
        drv_last[i]  = 1'b0;
    endtask

    // One return pulse per cycle for n cycles on (o,c).
    task automatic ret_credit(input int o, input int c, input int n);
        for (int k = 0; k < n; k++) begin
            credit_ret[o*CLS + c] = 1'b1;
            step();
            credit_ret[o*CLS + c] = 1'b0;
        end
    endtask

    initial begin
        reset      = 1'b1;
        credit_ret = '0;
        for (int i = 0; i < NI; i++) begin
            drv_data[i]  = '0;
            drv_valid[i] = 1'b0;
            drv_last[i]  = 1'b0;
            drv_dest[i]  = '0;
            drv_vc[i]    = '0;
        end

        // Monitor: every output write must match the head of that output's queue.
        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    for (int o = 0; o < NO; o++) begin
                        if (m_tvalid[o]) begin
                            if (exp_q[o].size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_flit out%0d: got %0h required none", o, m_tdata[o*DW +: DW]);
                            end else begin
                                check($sformatf("out%0d_flit", o),
                                      64'({m_tvc[o*2 +: 2], m_tlast[o], m_tdata[o*DW +: DW]}),
                                      64'(exp_q[o].pop_front()));
                            end
                            if (o == 1) cyc_log1.push_back(cyc);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_busy", 64'(o_out_busy), 64'(0));
        check("rst_tready", 64'(s_tready), 64'(0));
        check("rst_mvalid", 64'(m_tvalid), 64'(0));
        check("rst_mdata", 64'(m_tdata[63:0]), 64'(0));
        check("rst_credits", o_credits, {16{4'd8}});
        check("rst_overflow", 64'(o_credit_overflow), 64'(0));
        check("rst_sel", 64'(o_sel_input), 64'(0));

        // T1: 4-flit packet in0 -> out2 class 1; one bubble cycle, then lock.
        step();
        exp_pkt(0, 2, 1, 4, 1);
        fork
            send_pkt(0, 2, 1, 4, 1);
            begin
                @(negedge clk);
                check("t1_bubble_busy", 64'(o_out_busy[2]), 64'(0));
                check("t1_bubble_tready", 64'(s_tready[0]), 64'(0));
                @(negedge clk);
                check("t1_locked_busy", 64'(o_out_busy[2]), 64'(1));
                check("t1_locked_mvalid", 64'(m_tvalid[2]), 64'(1));
                check("t1_sel", 64'(o_sel_input[4 +: 2]), 64'(0));
            end
        join
        @(negedge clk);
        check("t1_credits", 64'(cred(2, 1)), 64'(4));
        check("t1_idle", 64'(o_out_busy[2]), 64'(0));
        step();
        ret_credit(2, 1, 4);
        @(negedge clk);
        check("t1_credits_back", 64'(cred(2, 1)), 64'(8));

        // T2: in0, in1, in3 one-flit packets to out1 together; RR order 0,1,3.
        step();
        cyc_log1.delete();
        exp_pkt(0, 1, 1, 1, 20);
        exp_pkt(1, 1, 1, 1, 21);
        exp_pkt(3, 1, 1, 1, 23);
        fork
            send_pkt(0, 1, 1, 1, 20);
            send_pkt(1, 1, 1, 1, 21);
            send_pkt(3, 1, 1, 1, 23);
        join
        repeat (2) step();
        check("t2_count", 64'(cyc_log1.size()), 64'(3));
        if (cyc_log1.size() == 3) begin
            check("t2_gap01", 64'(cyc_log1[1] - cyc_log1[0]), 64'(2));
            check("t2_gap13", 64'(cyc_log1[2] - cyc_log1[1]), 64'(2));
        end

        // T3: class 0 from in0 vs class 3 from in2 on out3; in2 goes first.
        exp_pkt(2, 3, 3, 2, 32);
        exp_pkt(0, 3, 0, 2, 30);
        fork
            send_pkt(0, 3, 0, 2, 30);
            send_pkt(2, 3, 3, 2, 32);
        join

        // T4: 10-flit packet to out0 class 2 with 8 credits; stall, then trickle returns.
        step();
        exp_pkt(1, 0, 2, 10, 40);
        fork
            send_pkt(1, 0, 2, 10, 40);
            begin
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (cred(0, 2) == 0) break;
                end
                check("t4_exhausted", 64'(cred(0, 2)), 64'(0));
                for (int k = 0; k < 3; k++) begin
                    check("t4_stall_tready", 64'(s_tready[1]), 64'(0));
                    check("t4_stall_busy", 64'(o_out_busy[0]), 64'(1));
                    check("t4_stall_mvalid", 64'(m_tvalid[0]), 64'(0));
                    @(negedge clk);
                end
                step();
                ret_credit(0, 2, 2);
            end
        join
        @(negedge clk);
        check("t4_done_busy", 64'(o_out_busy[0]), 64'(0));
        check("t4_done_credits", 64'(cred(0, 2)), 64'(0));
        step();
        ret_credit(0, 2, 8);
        @(negedge clk);
        check("t4_credits_back", 64'(cred(0, 2)), 64'(8));

        // T5: accept and return on the same (o,c) at 3 credits; then overflow.
        step();
        exp_pkt(2, 2, 0, 5, 50);
        send_pkt(2, 2, 0, 5, 50);
        @(negedge clk);
        check("t5_credits3", 64'(cred(2, 0)), 64'(3));
        step();
        exp_pkt(2, 2, 0, 1, 51);
        drv_valid[2] = 1'b1;
        drv_last[2]  = 1'b1;
        drv_dest[2]  = 2'd2;
        drv_vc[2]    = 2'd0;
        drv_data[2]  = mk(2, 51, 0);
        step();
        credit_ret[2*CLS + 0] = 1'b1;
        @(negedge clk);
        check("t5_tready", 64'(s_tready[2]), 64'(1));
        step();
        credit_ret[2*CLS + 0] = 1'b0;
        drv_valid[2] = 1'b0;
        drv_last[2]  = 1'b0;
        @(negedge clk);
        check("t5_credits_same", 64'(cred(2, 0)), 64'(3));
        check("t5_idle", 64'(o_out_busy[2]), 64'(0));
        check("t5_no_overflow", 64'(o_credit_overflow), 64'(0));
        step();
        ret_credit(2, 0, 5);
        @(negedge clk);
        check("t5_full", 64'(cred(2, 0)), 64'(8));
        check("t5_still_no_overflow", 64'(o_credit_overflow), 64'(0));
        step();
        ret_credit(2, 0, 1);
        @(negedge clk);
        check("t5_overflow", 64'(o_credit_overflow), 64'(1));
        check("t5_saturated", 64'(cred(2, 0)), 64'(8));

        // T6: reset while out0 and out1 are mid-packet.
        step();
        drv_valid[0] = 1'b1; drv_last[0] = 1'b0; drv_dest[0] = 2'd0; drv_vc[0] = 2'd1; drv_data[0] = mk(0, 60, 0);
        drv_valid[1] = 1'b1; drv_last[1] = 1'b0; drv_dest[1] = 2'd1; drv_vc[1] = 2'd1; drv_data[1] = mk(1, 61, 0);
        for (int k = 0; k < 2; k++) begin
            exp_q[0].push_back({2'd1, 1'b0, mk(0, 60, 0)});
            exp_q[1].push_back({2'd1, 1'b0, mk(1, 61, 0)});
        end
        step();
        @(negedge clk);
        check("t6_both_locked", 64'(o_out_busy[1:0]), 64'(3));
        step();
        step();
        reset        = 1'b1;
        drv_valid[0] = 1'b0;
        drv_valid[1] = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t6_busy", 64'(o_out_busy), 64'(0));
        check("t6_tready", 64'(s_tready), 64'(0));
        check("t6_credits", o_credits, {16{4'd8}});
        check("t6_overflow", 64'(o_credit_overflow), 64'(0));
        check("t6_sel", 64'(o_sel_input), 64'(0));

        // After reset out3 arbitrates from pointer 0 again: in0 before in1.
        step();
        exp_pkt(0, 3, 0, 1, 70);
        exp_pkt(1, 3, 0, 1, 71);
        fork
            send_pkt(0, 3, 0, 1, 70);
            send_pkt(1, 3, 0, 1, 71);
        join

        repeat (3) step();
        for (int o = 0; o < NO; o++)
            check($sformatf("out%0d_queue_left", o), 64'(exp_q[o].size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
